// File: rtl/dispatch_sink_stream_pkg.sv
// Shared types and helpers for the dispatch sink stream block.
package sink_stream_config;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    INDEX = 2'd2
  } drain_state_t;

  // Width needed to hold any count from 0 up to n inclusive.
  function automatic int snk_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dispatch_sink_stream_fifo.sv
// Synchronous frame FIFO. Pointers wrap mod DEPTH; a full flag separates full from empty.
module sink_frame_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q) && !full_q;
  assign full_o  = full_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    full_d   = full_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop && (wr_ptr_d == rd_ptr_q)) full_d = 1'b1;
    else if (do_pop && !do_push)                      full_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dispatch_sink_stream.sv
// Buffers network fire frames and streams each as a count beat followed by fired indices.
// Optional DISPATCH_SINK_FIRE_MASK_EN adds a fire_mask input applied when a frame is fetched.
module dispatch_sink_stream
  import sink_stream_config::*;
#(
  parameter int NUM_OUT     = 16,
  parameter int FRAME_DEPTH = 4,
  localparam int SNK_WIDTH  = snk_width(NUM_OUT)
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic                 net_valid,
  output logic                 net_ready,
  input  logic [NUM_OUT-1:0]   net_out,
`ifdef DISPATCH_SINK_FIRE_MASK_EN
  input  logic [NUM_OUT-1:0]   fire_mask,
`endif
  input  logic                 snk_ready,
  output logic                 snk_valid,
  output logic [SNK_WIDTH-1:0] snk,
  output logic                 snk_last,
  output logic                 busy
);

  function automatic logic [SNK_WIDTH-1:0] popcount(input logic [NUM_OUT-1:0] v);
    logic [SNK_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_OUT; i++) c = c + SNK_WIDTH'(v[i]);
    return c;
  endfunction

  // Lowest set bit wins: scanning downwards lets the lowest match overwrite.
  function automatic logic [SNK_WIDTH-1:0] lowest_set(input logic [NUM_OUT-1:0] v);
    logic [SNK_WIDTH-1:0] idx;
    idx = '0;
    for (int i = NUM_OUT - 1; i >= 0; i--) if (v[i]) idx = SNK_WIDTH'(i);
    return idx;
  endfunction

  drain_state_t         state_q, state_d;
  logic [NUM_OUT-1:0]   pend_q, pend_d;
  logic [SNK_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_OUT-1:0]   fifo_head, pend_fetch, pend_rest;
  logic                 fifo_full, fifo_empty, fifo_pop;

  sink_frame_fifo #(
    .WIDTH (NUM_OUT),
    .DEPTH (FRAME_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .arstn   (arstn),
    .push_i  (net_valid && net_ready),
    .pop_i   (fifo_pop),
    .data_i  (net_out),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign net_ready = !fifo_full && arstn;
  assign busy      = !fifo_empty || (state_q != IDLE);

`ifdef DISPATCH_SINK_FIRE_MASK_EN
  assign pend_fetch = fifo_head & fire_mask;
`else
  assign pend_fetch = fifo_head;
`endif

  // Pending set with its lowest fired output removed.
  assign pend_rest = pend_q & (pend_q - NUM_OUT'(1));

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    fifo_pop  = 1'b0;
    snk_valid = 1'b0;
    snk       = '0;
    snk_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          pend_d   = pend_fetch;
          cnt_d    = popcount(pend_fetch);
          state_d  = COUNT;
        end
      end
      COUNT: begin
        snk_valid = 1'b1;
        snk       = cnt_q;
        snk_last  = (cnt_q == '0);
        if (snk_ready) state_d = (cnt_q == '0) ? IDLE : INDEX;
      end
      INDEX: begin
        snk_valid = 1'b1;
        snk       = lowest_set(pend_q);
        snk_last  = (pend_rest == '0);
        if (snk_ready) begin
          pend_d = pend_rest;
          if (pend_rest == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arstn) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    pend_q <= pend_d;
    cnt_q  <= cnt_d;
  end

endmodule
